// File: rtl/pacman_mover_pkg.sv
// Shared sprite definitions: heading codes, default playfield borders and mover FSM states.
package pacman_mover_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam int DEF_BORDER_X_MIN = 1;
    localparam int DEF_BORDER_X_MAX = 28;
    localparam int DEF_BORDER_Y_MIN = 1;
    localparam int DEF_BORDER_Y_MAX = 28;
    localparam int DEF_TUNNEL_ROW   = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WANT,
        ST_CHK_WANT,
        ST_RD_CUR,
        ST_CHK_CUR,
        ST_UPDATE
    } mover_state_t;

endpackage

// File: rtl/pacman_next_tile.sv
// Combinational neighbour-tile calculator with tunnel wrap and border check.
module pacman_next_tile
    import pacman_mover_pkg::*;
#(
    parameter int BORDER_X_MIN = DEF_BORDER_X_MIN,
    parameter int BORDER_X_MAX = DEF_BORDER_X_MAX,
    parameter int BORDER_Y_MIN = DEF_BORDER_Y_MIN,
    parameter int BORDER_Y_MAX = DEF_BORDER_Y_MAX,
    parameter int TUNNEL_ROW   = DEF_TUNNEL_ROW
) (
    input  logic [4:0] x,
    input  logic [4:0] y,
    input  logic [1:0] dir,
    output logic [4:0] tx,
    output logic [4:0] ty,
    output logic       out_of_bounds
);

    logic on_tunnel_row;

    always_comb begin
        on_tunnel_row = (y == 5'(TUNNEL_ROW));
        tx = x;
        ty = y;
        case (dir)
            DIR_UP:    ty = y - 5'd1;
            DIR_LEFT:  tx = x - 5'd1;
            DIR_DOWN:  ty = y + 5'd1;
            default:   tx = x + 5'd1;
        endcase
        // Horizontal edges of the tunnel row wrap to the opposite border.
        if (on_tunnel_row && dir == DIR_LEFT && x == 5'(BORDER_X_MIN))
            tx = 5'(BORDER_X_MAX);
        if (on_tunnel_row && dir == DIR_RIGHT && x == 5'(BORDER_X_MAX))
            tx = 5'(BORDER_X_MIN);
        out_of_bounds = (tx < 5'(BORDER_X_MIN)) || (tx > 5'(BORDER_X_MAX)) ||
                        (ty < 5'(BORDER_Y_MIN)) || (ty > 5'(BORDER_Y_MAX));
    end

endmodule

// File: rtl/pacman_mover.sv
// Tile-based sprite mover: every MOVE_FRAMES frames tries the requested heading, then the current one.
module pacman_mover
    import pacman_mover_pkg::*;
#(
    parameter int BORDER_X_MIN = DEF_BORDER_X_MIN,
    parameter int BORDER_X_MAX = DEF_BORDER_X_MAX,
    parameter int BORDER_Y_MIN = DEF_BORDER_Y_MIN,
    parameter int BORDER_Y_MAX = DEF_BORDER_Y_MAX,
    parameter int START_X      = 14,
    parameter int START_Y      = 23,
    parameter int START_DIR    = 1,
    parameter int MOVE_FRAMES  = 8,
    parameter int TUNNEL_ROW   = DEF_TUNNEL_ROW
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       joy_valid,
    input  logic [1:0] joy_dir,
    output logic       map_rd,
    output logic [4:0] map_x,
    output logic [4:0] map_y,
    input  logic       map_wall,
    output logic [4:0] xpos,
    output logic [4:0] ypos,
    output logic [1:0] direction,
    output logic       moving,
    output logic       step_done
);

    localparam int CW = $clog2(MOVE_FRAMES + 1);

    mover_state_t state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic [1:0]    want_dir_reg, att_dir_reg, mv_dir_reg;
    logic [4:0]    mv_x_reg, mv_y_reg;
    logic          move_reg;
    logic          trigger, use_cur, tile_free;
    logic [1:0]    nt_dir;
    logic [4:0]    nt_x, nt_y;
    logic          nt_oob;

    assign trigger   = ce && (cnt_reg == CW'(MOVE_FRAMES - 1));
    assign use_cur   = (state_reg == ST_RD_CUR) || (state_reg == ST_CHK_CUR);
    assign nt_dir    = use_cur ? direction : att_dir_reg;
    assign tile_free = !nt_oob && !map_wall;

    pacman_next_tile #(
        .BORDER_X_MIN(BORDER_X_MIN),
        .BORDER_X_MAX(BORDER_X_MAX),
        .BORDER_Y_MIN(BORDER_Y_MIN),
        .BORDER_Y_MAX(BORDER_Y_MAX),
        .TUNNEL_ROW  (TUNNEL_ROW)
    ) u_next_tile (
        .x            (xpos),
        .y            (ypos),
        .dir          (nt_dir),
        .tx           (nt_x),
        .ty           (nt_y),
        .out_of_bounds(nt_oob)
    );

    always_ff @(posedge clk) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (trigger) state_next = ST_RD_WANT;
            ST_RD_WANT:  state_next = ST_CHK_WANT;
            // An out-of-bounds target never issued a read, so map_wall is not consulted.
            ST_CHK_WANT: if (tile_free || att_dir_reg == direction) state_next = ST_UPDATE;
                         else                                       state_next = ST_RD_CUR;
            ST_RD_CUR:   state_next = ST_CHK_CUR;
            ST_CHK_CUR:  state_next = ST_UPDATE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        map_rd    = ((state_reg == ST_RD_WANT) || (state_reg == ST_RD_CUR)) && !nt_oob;
        map_x     = nt_x;
        map_y     = nt_y;
        step_done = (state_reg == ST_UPDATE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg      <= '0;
            want_dir_reg <= 2'(START_DIR);
            att_dir_reg  <= 2'(START_DIR);
            mv_dir_reg   <= 2'(START_DIR);
            mv_x_reg     <= 5'(START_X);
            mv_y_reg     <= 5'(START_Y);
            move_reg     <= 1'b0;
            xpos         <= 5'(START_X);
            ypos         <= 5'(START_Y);
            direction    <= 2'(START_DIR);
            moving       <= 1'b0;
        end else begin
            if (ce) cnt_reg <= trigger ? '0 : cnt_reg + CW'(1);
            if (joy_valid) want_dir_reg <= joy_dir;
            // Snapshot the heading at trigger so a same-cycle joystick request is honoured.
            if (state_reg == ST_IDLE && trigger)
                att_dir_reg <= joy_valid ? joy_dir : want_dir_reg;
            case (state_reg)
                ST_RD_WANT: move_reg <= 1'b0;
                ST_CHK_WANT: if (tile_free) begin
                    move_reg   <= 1'b1;
                    mv_x_reg   <= nt_x;
                    mv_y_reg   <= nt_y;
                    mv_dir_reg <= att_dir_reg;
                end
                ST_CHK_CUR: if (tile_free) begin
                    move_reg   <= 1'b1;
                    mv_x_reg   <= nt_x;
                    mv_y_reg   <= nt_y;
                    mv_dir_reg <= direction;
                end
                ST_UPDATE: begin
                    moving <= move_reg;
                    if (move_reg) begin
                        xpos      <= mv_x_reg;
                        ypos      <= mv_y_reg;
                        direction <= mv_dir_reg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pacman_mover.sv
// Directed bench for pacman_mover with a behavioural tile map answering one clk after map_rd.
module tb_pacman_mover;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b0;
    logic       joy_valid = 1'b0;
    logic [1:0] joy_dir = 2'd0;
    logic       map_rd;
    logic [4:0] map_x, map_y;
    logic       map_wall = 1'b0;
    logic [4:0] xpos, ypos;
    logic [1:0] direction;
    logic       moving, step_done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int rd_cnt = 0;
    bit walls [0:31][0:31];

    pacman_mover dut (
        .clk(clk), .reset(reset), .ce(ce), .joy_valid(joy_valid), .joy_dir(joy_dir),
        .map_rd(map_rd), .map_x(map_x), .map_y(map_y), .map_wall(map_wall),
        .xpos(xpos), .ypos(ypos), .direction(direction), .moving(moving),
        .step_done(step_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        map_wall <= map_rd ? walls[map_y][map_x] : 1'b0;
        if (step_done) done_cnt <= done_cnt + 1;
        if (map_rd)    rd_cnt   <= rd_cnt + 1;
    end

    task automatic pulse_ce();
        @(negedge clk) ce = 1'b1;
        @(negedge clk) ce = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic do_step();
        repeat (8) pulse_ce();
        repeat (2) @(negedge clk);
    endtask

    task automatic set_joy(input logic [1:0] d);
        @(negedge clk) begin joy_valid = 1'b1; joy_dir = d; end
        @(negedge clk) joy_valid = 1'b0;
    endtask

    task automatic check_pos(input string name, input int ex, input int ey, input int ed, input int em);
        checks++;
        if (xpos !== 5'(ex) || ypos !== 5'(ey) || direction !== 2'(ed) || moving !== 1'(em)) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d dir=%0d moving=%0b, expected x=%0d y=%0d dir=%0d moving=%0d",
                     name, xpos, ypos, direction, moving, ex, ey, ed, em);
        end
    endtask

    task automatic check_cnt(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_pos("reset_state", 14, 23, 1, 0);
        checks++;
        if (step_done !== 1'b0 || map_rd !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: got step_done=%0b map_rd=%0b expected 0 0", step_done, map_rd);
        end
        $display("reset: x=%0d y=%0d dir=%0d", xpos, ypos, direction);
    endtask

    task automatic test_corridor();
        int d0, r0;
        d0 = done_cnt; r0 = rd_cnt;
        do_step();
        check_pos("corridor", 13, 23, 1, 1);
        check_cnt("corridor_done", done_cnt - d0, 1);
        check_cnt("corridor_reads", rd_cnt - r0, 1);
        $display("corridor: x=%0d y=%0d", xpos, ypos);
    endtask

    task automatic test_turn_blocked();
        int r0;
        walls[22][13] = 1'b1;
        set_joy(2'd0);
        r0 = rd_cnt;
        do_step();
        check_pos("turn_blocked", 12, 23, 1, 1);
        check_cnt("turn_blocked_reads", rd_cnt - r0, 2);
        walls[22][13] = 1'b0;
        // want_dir must still be up: with the wall gone the next step goes up.
        do_step();
        check_pos("want_dir_kept", 12, 22, 0, 1);
        $display("turn_blocked: x=%0d y=%0d dir=%0d", xpos, ypos, direction);
    endtask

    task automatic test_turn();
        set_joy(2'd2);
        do_step();
        check_pos("back_down", 12, 23, 2, 1);
        set_joy(2'd3);
        do_step();
        check_pos("back_right", 13, 23, 3, 1);
        set_joy(2'd0);
        do_step();
        check_pos("turn", 13, 22, 0, 1);
        $display("turn: x=%0d y=%0d dir=%0d", xpos, ypos, direction);
    endtask

    task automatic test_dead_end();
        int d0, r0;
        walls[22][12] = 1'b1;
        walls[21][13] = 1'b1;
        set_joy(2'd1);
        d0 = done_cnt; r0 = rd_cnt;
        do_step();
        check_pos("dead_end", 13, 22, 0, 0);
        check_cnt("dead_end_done", done_cnt - d0, 1);
        check_cnt("dead_end_reads", rd_cnt - r0, 2);
        walls[22][12] = 1'b0;
        walls[21][13] = 1'b0;
        $display("dead_end: x=%0d y=%0d moving=%0b", xpos, ypos, moving);
    endtask

    task automatic test_border_tunnel();
        int d0, r0;
        set_joy(2'd0);
        repeat (8) do_step();
        check_pos("reach_row14", 13, 14, 0, 1);
        set_joy(2'd1);
        repeat (12) do_step();
        check_pos("reach_tunnel_edge", 1, 14, 1, 1);
        r0 = rd_cnt;
        do_step();
        check_pos("tunnel_wrap", 28, 14, 1, 1);
        check_cnt("tunnel_reads", rd_cnt - r0, 1);
        set_joy(2'd0);
        repeat (9) do_step();
        set_joy(2'd1);
        repeat (27) do_step();
        check_pos("reach_border", 1, 5, 1, 1);
        d0 = done_cnt; r0 = rd_cnt;
        do_step();
        check_pos("border_hold", 1, 5, 1, 0);
        check_cnt("border_reads", rd_cnt - r0, 0);
        check_cnt("border_done", done_cnt - d0, 1);
        $display("border: x=%0d y=%0d moving=%0b", xpos, ypos, moving);
    endtask

    task automatic test_reset_mid_step();
        int d0;
        set_joy(2'd2);
        repeat (7) pulse_ce();
        @(negedge clk) ce = 1'b1;
        @(negedge clk) ce = 1'b0;
        // DUT now in RD_WANT; one more clk puts it in CHK_WANT.
        @(negedge clk) reset = 1'b1;
        d0 = done_cnt;
        @(negedge clk) reset = 1'b0;
        repeat (10) @(negedge clk);
        check_pos("reset_mid", 14, 23, 1, 0);
        check_cnt("reset_mid_done", done_cnt - d0, 0);
        do_step();
        check_pos("reset_mid_want_dir", 13, 23, 1, 1);
        $display("reset_mid: x=%0d y=%0d dir=%0d", xpos, ypos, direction);
    endtask

    initial begin
        for (int yy = 0; yy < 32; yy++)
            for (int xx = 0; xx < 32; xx++)
                walls[yy][xx] = 1'b0;
        test_reset();
        test_corridor();
        test_turn_blocked();
        test_turn();
        test_dead_end();
        test_border_tunnel();
        test_reset_mid_step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
